hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).

---
 rtl/mips_hz_pkg.sv | 28 ++
 rtl/hazard_fwd_unit.sv | 48 ++++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_hz_pkg.sv
// Shared types for the MIPS hazard controller: forwarding codes, FSM states and the
// source/destination match used by every producer comparison.
package mips_hz_pkg;

    localparam int HZ_MAX_AW = 8;

    typedef logic [HZ_MAX_AW-1:0] hz_reg_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

    // $0 is hard-wired zero, so it never produces a dependency.
    function automatic logic reg_match(input hz_reg_t src, input logic src_rd,
                                       input hz_reg_t dst, input logic dst_wr);
        return src_rd && dst_wr && (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Per-operand dependency check: raises hazard when the ID source must wait and picks
// the EX-operand forwarding source. HAZARD_FWD_EN selects forwarding vs. full interlock.
module hazard_fwd_unit
    import mips_hz_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              src_rd,
    input  logic [REG_AW-1:0] ex_wreg,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_wreg,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_wreg,
    input  logic              wb_regwrite,
    output logic              hazard,
    output logic [1:0]        fwd
);

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    assign hit_ex  = reg_match(hz_reg_t'(src), src_rd, hz_reg_t'(ex_wreg),  ex_regwrite);
    assign hit_mem = reg_match(hz_reg_t'(src), src_rd, hz_reg_t'(mem_wreg), mem_regwrite);
    assign hit_wb  = reg_match(hz_reg_t'(src), src_rd, hz_reg_t'(wb_wreg),  wb_regwrite);

`ifdef HAZARD_FWD_EN
    // Only a load in EX cannot be bypassed; its data appears one stage later.
    assign hazard = hit_ex && ex_memread;

    always_comb begin
        fwd = FWD_REG;
        if (hit_ex)       fwd = FWD_EX;
        else if (hit_mem) fwd = FWD_MEM;
        else if (hit_wb)  fwd = FWD_WB;
    end
`else
    logic unused_memread;

    // Register file is not write-through, so any in-flight writer blocks the read.
    assign unused_memread = ex_memread;
    assign hazard         = hit_ex || hit_mem || hit_wb;
    assign fwd            = FWD_REG;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipe: stall FSM, hold/bubble/flush
// drive, EX forwarding selects and stall/redirect counters. Build option: HAZARD_FWD_EN.
//
//  state | meaning
//  RUN   | normal issue, no hold active last cycle
//  STALL | ID held with a bubble into EX last cycle
//  FLUSH | cycle after a redirect; ID/EX/MEM hold bubbles, detection masked
module hazard_ctrl
    import mips_hz_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] ex_wreg,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_wreg,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_wreg,
    input  logic              wb_regwrite,
    input  logic              mem_redirect,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              idex_bubble,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    hz_state_t cur_st;
    hz_state_t nxt_st;
    logic      haz_a;
    logic      haz_b;
    logic      hazard;

    hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .src          (id_rs),
        .src_rd       (id_use_rs),
        .ex_wreg      (ex_wreg),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .mem_wreg     (mem_wreg),
        .mem_regwrite (mem_regwrite),
        .wb_wreg      (wb_wreg),
        .wb_regwrite  (wb_regwrite),
        .hazard       (haz_a),
        .fwd          (fwd_a)
    );

    hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .src          (id_rt),
        .src_rd       (id_use_rt),
        .ex_wreg      (ex_wreg),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .mem_wreg     (mem_wreg),
        .mem_regwrite (mem_regwrite),
        .wb_wreg      (wb_wreg),
        .wb_regwrite  (wb_regwrite),
        .hazard       (haz_b),
        .fwd          (fwd_b)
    );

    assign hazard = haz_a || haz_b;
    assign state  = cur_st;

    always_ff @(posedge CLK) begin
        if (RST) cur_st <= RUN;
        else     cur_st <= nxt_st;
    end

    always_comb begin
        nxt_st = RUN;
        case (cur_st)
            FLUSH:   nxt_st = RUN;
            default: begin
                if (mem_redirect) nxt_st = FLUSH;
                else if (hazard)  nxt_st = STALL;
            end
        endcase
    end

    // In FLUSH both ID and MEM hold bubbles, so neither hazards nor redirects are real.
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_bubble = 1'b0;
        flush       = 1'b0;
        if (cur_st != FLUSH) begin
            if (mem_redirect) begin
                flush = 1'b1;
            end else if (hazard) begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (idex_bubble && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush && (flush_events != {CNT_W{1'b1}}))
                flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations plus
// randomized pipeline traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  id_rs, id_rt, ex_wreg, mem_wreg, wb_wreg;
    logic        id_use_rs, id_use_rt, ex_regwrite, ex_memread;
    logic        mem_regwrite, wb_regwrite, mem_redirect;
    logic        pc_hold, ifid_hold, idex_bubble, flush;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [15:0] stall_cycles, flush_events;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // model: 0 = running, 1 = stalled last cycle, 2 = one-cycle post-redirect window
    int m_st    = 0;
    int m_stall = 0;
    int m_flush = 0;

    hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .ex_wreg      (ex_wreg),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .mem_wreg     (mem_wreg),
        .mem_regwrite (mem_regwrite),
        .wb_wreg      (wb_wreg),
        .wb_regwrite  (wb_regwrite),
        .mem_redirect (mem_redirect),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .idex_bubble  (idex_bubble),
        .flush        (flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .state        (state),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit src_waits(input logic [4:0] s, input logic u);
        if (!u || s == 5'd0) return 1'b0;
`ifdef HAZARD_FWD_EN
        return ex_memread && ex_regwrite && ex_wreg == s;
`else
        return (ex_regwrite && ex_wreg == s) || (mem_regwrite && mem_wreg == s) ||
               (wb_regwrite && wb_wreg == s);
`endif
    endfunction

    function automatic int src_sel(input logic [4:0] s, input logic u);
`ifdef HAZARD_FWD_EN
        if (!u || s == 5'd0)                return 0;
        if (ex_regwrite  && ex_wreg  == s)  return 1;
        if (mem_regwrite && mem_wreg == s)  return 2;
        if (wb_regwrite  && wb_wreg  == s)  return 3;
        return 0;
`else
        return (s == 5'd31 && !u) ? 0 : 0;
`endif
    endfunction

    function automatic bit exp_flush();
        return (m_st != 2) && mem_redirect;
    endfunction

    function automatic bit exp_stall();
        return (m_st != 2) && !mem_redirect &&
               (src_waits(id_rs, id_use_rs) || src_waits(id_rt, id_use_rt));
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_st = 0; m_stall = 0; m_flush = 0;
        end else begin
            bit fl, st;
            fl = exp_flush();
            st = exp_stall();
            if (st) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            if (fl) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
            m_st = fl ? 2 : (st ? 1 : 0);
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            bit fl, st;
            fl = exp_flush();
            st = exp_stall();
            chk("state",        32'(state),        32'(m_st));
            chk("pc_hold",      32'(pc_hold),      32'(st));
            chk("ifid_hold",    32'(ifid_hold),    32'(st));
            chk("idex_bubble",  32'(idex_bubble),  32'(st));
            chk("flush",        32'(flush),        32'(fl));
            chk("fwd_a",        32'(fwd_a),        32'(src_sel(id_rs, id_use_rs)));
            chk("fwd_b",        32'(fwd_b),        32'(src_sel(id_rt, id_use_rt)));
            chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
            chk("flush_events", 32'(flush_events), 32'(m_flush));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_wreg = 0; ex_regwrite = 0; ex_memread = 0;
        mem_wreg = 0; mem_regwrite = 0; wb_wreg = 0; wb_regwrite = 0;
        mem_redirect = 0;
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic load_use();
        ex_wreg = 5'd2; ex_regwrite = 1; ex_memread = 1;
        id_rs = 5'd2; id_use_rs = 1;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        chk_en = 1'b1;

        @(negedge CLK);
        chk("rst_state", 32'(state), 0);
        chk("rst_pc_hold", 32'(pc_hold), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_stall_cycles", 32'(stall_cycles), 0);
        tick();

        // lw $2 in EX, add reading $2 in ID
        load_use();
        @(negedge CLK);
        chk("lu_pc_hold", 32'(pc_hold), 1);
        chk("lu_idex_bubble", 32'(idex_bubble), 1);
        tick();
        ex_wreg = 0; ex_regwrite = 0; ex_memread = 0;
        mem_wreg = 5'd2; mem_regwrite = 1;
        @(negedge CLK);
        chk("lu_state", 32'(state), 1);
`ifdef HAZARD_FWD_EN
        chk("lu_release", 32'(pc_hold), 0);
        chk("lu_fwd_a", 32'(fwd_a), 2);
        chk("lu_stall_cycles", 32'(stall_cycles), 1);
`else
        chk("lu_hold_mem", 32'(pc_hold), 1);
`endif
        tick();
        idle();
        tick();

        // add $3 travelling EX -> MEM -> WB, ID reads it on rt
        do_reset();
        ex_wreg = 5'd3; ex_regwrite = 1; id_rt = 5'd3; id_use_rt = 1;
        @(negedge CLK);
`ifdef HAZARD_FWD_EN
        chk("alu_no_stall", 32'(pc_hold), 0);
        chk("alu_fwd_b", 32'(fwd_b), 1);
`else
        chk("alu_stall", 32'(pc_hold), 1);
`endif
        tick();
        ex_wreg = 0; ex_regwrite = 0; mem_wreg = 5'd3; mem_regwrite = 1;
        tick();
        mem_wreg = 0; mem_regwrite = 0; wb_wreg = 5'd3; wb_regwrite = 1;
        tick();
        wb_wreg = 0; wb_regwrite = 0;
        @(negedge CLK);
        chk("alu_drained", 32'(pc_hold), 0);
`ifdef HAZARD_FWD_EN
        chk("alu_stall_cycles", 32'(stall_cycles), 0);
`else
        chk("alu_stall_cycles", 32'(stall_cycles), 3);
`endif
        tick();

        // redirect wins over a coincident load-use hazard
        do_reset();
        load_use();
        mem_redirect = 1;
        @(negedge CLK);
        chk("rd_flush", 32'(flush), 1);
        chk("rd_pc_hold", 32'(pc_hold), 0);
        chk("rd_idex_bubble", 32'(idex_bubble), 0);
        tick();
        @(negedge CLK);
        chk("rd_state_flush", 32'(state), 2);
        chk("rd_masked_flush", 32'(flush), 0);
        chk("rd_masked_hold", 32'(pc_hold), 0);
        tick();
        idle();
        @(negedge CLK);
        chk("rd_state_run", 32'(state), 0);
        chk("rd_flush_events", 32'(flush_events), 1);
        chk("rd_stall_cycles", 32'(stall_cycles), 0);
        tick();

        // $0 never matches
        idle();
        id_rs = 0; id_use_rs = 1; ex_wreg = 0; ex_regwrite = 1; ex_memread = 1;
        @(negedge CLK);
        chk("r0_pc_hold", 32'(pc_hold), 0);
        chk("r0_fwd_a", 32'(fwd_a), 0);
        tick();

        // reset while stalled
        idle();
        load_use();
        tick();
        @(negedge CLK);
        chk("rs_in_stall", 32'(state), 1);
        RST = 1'b1;
        idle();
        tick();
        @(negedge CLK);
        chk("rs_state", 32'(state), 0);
        chk("rs_pc_hold", 32'(pc_hold), 0);
        chk("rs_stall_cycles", 32'(stall_cycles), 0);
        chk("rs_flush_events", 32'(flush_events), 0);
        RST = 1'b0;
        tick();

        // random pipeline traffic
        repeat (3000) begin
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_use_rs    = 1'($urandom_range(0, 1));
            id_use_rt    = 1'($urandom_range(0, 1));
            ex_wreg      = 5'($urandom_range(0, 3));
            ex_regwrite  = 1'($urandom_range(0, 1));
            ex_memread   = ($urandom_range(0, 9) < 3);
            mem_wreg     = 5'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom_range(0, 1));
            wb_wreg      = 5'($urandom_range(0, 3));
            wb_regwrite  = 1'($urandom_range(0, 1));
            mem_redirect = ($urandom_range(0, 7) == 0);
            RST          = ($urandom_range(0, 199) == 0);
            tick();
        end
        RST = 1'b0;

        // saturation of the stall counter
        do_reset();
        load_use();
        repeat (65541) tick();
        @(negedge CLK);
        chk("sat_stall_cycles", 32'(stall_cycles), 32'h0000_FFFF);
        chk("sat_state", 32'(state), 1);
        idle();
        tick();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
